// File: rtl/wb_pkg.sv
// Shared types for the Wishbone memory responder: FSM states, pipe entry
// layout and the byte-lane address helper.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_ABORT
  } state_t;

  // Widest data bus the pipe entry can carry; narrower buses use the low bits.
  localparam int PIPE_DMAX = 64;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [PIPE_DMAX-1:0] data;
  } pipe_entry_t;

  // Number of low address bits that select a byte within one data word.
  function automatic int bytebits(input int dwidth);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < (dwidth / 8)) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle; dat_m carries master write data, dat_s slave read data.
interface if_wb #(
  parameter int AWIDTH = 27,
  parameter int DWIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [AWIDTH-1:0]     adr;
  logic [DWIDTH/8-1:0]   sel;
  logic [DWIDTH-1:0]     dat_m;
  logic [DWIDTH-1:0]     dat_s;
  logic                  ack;
  logic                  stall;

  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_bram.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// write-first read port (a write returns the merged word it just stored).
module wb_bram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [AWIDTH-1:0]   addr_i,
  input  logic [DWIDTH/8-1:0] sel_i,
  input  logic [DWIDTH-1:0]   wdata_i,
  output logic [DWIDTH-1:0]   rdata_o
);

  localparam int LANES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_d;
  logic [DWIDTH-1:0] rdata_q;

  always_comb begin
    rdata_d = mem[addr_i];
    for (int k = 0; k < LANES; k++) begin
      if (we_i && sel_i[k]) rdata_d[8*k +: 8] = wdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (we_i && sel_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone slave serving block RAM with fixed-latency in-order acks,
// programmable stall back-pressure and abort of outstanding requests on cyc drop.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int AWIDTH        = 27,
  parameter int DWIDTH        = 32,
  parameter int MEMWORDS_LOG2 = 10,
  parameter int LATENCY       = 2,
  parameter int STALL_CYCLES  = 0
) (
  input logic clk_i,
  input logic rst_i,
  if_wb.slave bus
);

  localparam int         BYTEBITS   = bytebits(DWIDTH);
  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES);

  state_t                    state_q, state_d;
  logic [3:0]                stall_cnt_q, stall_cnt_d;
  logic [DWIDTH-1:0]         hold_q, hold_d;
  pipe_entry_t               pipe_d [LATENCY];
  logic [LATENCY-1:0]        pipe_vld_q;
  logic                      pipe_we_q [LATENCY];
  logic [DWIDTH-1:0]         pipe_dat_q [LATENCY];

  logic                      stall;
  logic                      accept;
  logic                      flush;
  logic                      pipe_busy;
  logic                      ack;
  logic                      read_ack;
  logic                      tail_we;
  logic [DWIDTH-1:0]         tail_data;
  logic [DWIDTH-1:0]         ram_rdata;
  logic [MEMWORDS_LOG2-1:0]  word_idx;
  logic                      adr_unused;

  assign stall     = (stall_cnt_q != 4'd0);
  assign accept    = bus.cyc & bus.stb & ~stall;
  assign pipe_busy = |pipe_vld_q;
  assign word_idx  = bus.adr[BYTEBITS+MEMWORDS_LOG2-1:BYTEBITS];
  // Upper bits alias onto the RAM; sub-word bits are covered by sel.
  assign adr_unused = ^{bus.adr[AWIDTH-1:BYTEBITS+MEMWORDS_LOG2], bus.adr[BYTEBITS-1:0]};

  wb_bram #(
    .AWIDTH (MEMWORDS_LOG2),
    .DWIDTH (DWIDTH)
  ) u_bram (
    .clk_i   (clk_i),
    .en_i    (accept),
    .we_i    (bus.we),
    .addr_i  (word_idx),
    .sel_i   (bus.sel),
    .wdata_i (bus.dat_m),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cyc) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!bus.cyc) begin
          flush   = 1'b1;
          state_d = pipe_busy ? S_ABORT : S_IDLE;
        end
      end
      S_ABORT: begin
        flush   = 1'b1;
        state_d = bus.cyc ? S_ACTIVE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept)     stall_cnt_d = STALL_LOAD;
    else if (stall) stall_cnt_d = stall_cnt_q - 4'd1;
  end

  // Stage 0 holds the request just accepted; the RAM word it read appears one
  // cycle later, so stage 1 (or the tail when LATENCY is 1) takes it from the RAM.
  always_comb begin
    pipe_d[0].valid = accept;
    pipe_d[0].we    = bus.we;
    pipe_d[0].data  = PIPE_DMAX'(ram_rdata);
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i].valid = pipe_vld_q[i-1] & ~flush;
      pipe_d[i].we    = pipe_we_q[i-1];
      pipe_d[i].data  = (i == 1) ? PIPE_DMAX'(ram_rdata) : PIPE_DMAX'(pipe_dat_q[i-1]);
    end
  end

  if (DWIDTH < PIPE_DMAX) begin : g_pad
    logic pad_unused;
    always_comb begin
      pad_unused = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pad_unused = pad_unused ^ (^pipe_d[i].data[PIPE_DMAX-1:DWIDTH]);
      end
    end
  end

  assign tail_we   = pipe_we_q[LATENCY-1];
  assign tail_data = (LATENCY == 1) ? ram_rdata : pipe_dat_q[LATENCY-1];
  assign ack       = pipe_vld_q[LATENCY-1] & bus.cyc & (state_q == S_ACTIVE);
  assign read_ack  = ack & ~tail_we;

  always_comb begin
    hold_d = hold_q;
    if (read_ack) hold_d = tail_data;
  end

  assign bus.ack   = ack;
  assign bus.stall = stall;
  assign bus.dat_s = hold_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      hold_q      <= '0;
      pipe_vld_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      hold_q      <= hold_d;
      for (int i = 0; i < LATENCY; i++) pipe_vld_q[i] <= pipe_d[i].valid;
    end
  end

  // Payload follows the valid bits and needs no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_we_q[i]  <= pipe_d[i].we;
      pipe_dat_q[i] <= pipe_d[i].data[DWIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: three instances with different latency
// and stall settings, driven cycle by cycle against hand-computed expectations.
module tb_wb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        cyc_r [3];
  logic        stb_r [3];
  logic        we_r  [3];
  logic [26:0] adr_r [3];
  logic [3:0]  sel_r [3];
  logic [31:0] dat_r [3];
  logic        ack_w   [3];
  logic        stall_w [3];
  logic [31:0] dato_w  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY 2, no stall. Instance 1: LATENCY 2, stall 3. Instance 2: LATENCY 4, no stall.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    if_wb #(.AWIDTH(27), .DWIDTH(32)) bus ();
    assign bus.cyc   = cyc_r[g];
    assign bus.stb   = stb_r[g];
    assign bus.we    = we_r[g];
    assign bus.adr   = adr_r[g];
    assign bus.sel   = sel_r[g];
    assign bus.dat_m = dat_r[g];
    assign ack_w[g]   = bus.ack;
    assign stall_w[g] = bus.stall;
    assign dato_w[g]  = bus.dat_s;
    wb_mem_responder #(
      .AWIDTH        (27),
      .DWIDTH        (32),
      .MEMWORDS_LOG2 (10),
      .LATENCY       ((g == 2) ? 4 : 2),
      .STALL_CYCLES  ((g == 1) ? 3 : 0)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic c, input logic s, input logic w,
                       input logic [26:0] a, input logic [3:0] sl, input logic [31:0] d);
    cyc_r[k] = c;
    stb_r[k] = s;
    we_r[k]  = w;
    adr_r[k] = a;
    sel_r[k] = sl;
    dat_r[k] = d;
  endtask

  task automatic idle(input int k, input logic c);
    drive(k, c, 1'b0, 1'b0, 27'h0, 4'h0, 32'h0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) idle(k, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_ack%0d", k), 32'(ack_w[k]), 32'h0);
      check_eq($sformatf("rst_stall%0d", k), 32'(stall_w[k]), 32'h0);
      check_eq($sformatf("rst_dat%0d", k), dato_w[k], 32'h0);
    end
    adv();
    rst = 1'b0;

    // Write then read one word, LATENCY 2.
    drive(0, 1, 1, 1, 27'h100, 4'hf, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("t1_c0_ack", 32'(ack_w[0]), 32'h0);
    check_eq("t1_c0_stall", 32'(stall_w[0]), 32'h0);
    adv();
    drive(0, 1, 1, 0, 27'h100, 4'hf, 32'h0);
    @(negedge clk);
    check_eq("t1_c1_ack", 32'(ack_w[0]), 32'h0);
    adv();
    idle(0, 1);
    @(negedge clk);
    check_eq("t1_wr_ack", 32'(ack_w[0]), 32'h1);
    check_eq("t1_wr_dat", dato_w[0], 32'h0);
    adv();
    @(negedge clk);
    check_eq("t1_rd_ack", 32'(ack_w[0]), 32'h1);
    check_eq("t1_rd_dat", dato_w[0], 32'hDEADBEEF);
    adv();
    @(negedge clk);
    check_eq("t1_c4_ack", 32'(ack_w[0]), 32'h0);
    check_eq("t1_c4_hold", dato_w[0], 32'hDEADBEEF);
    adv();
    idle(0, 0);
    @(negedge clk);
    check_eq("t1_c5_ack", 32'(ack_w[0]), 32'h0);
    adv();

    // Byte-lane merge with read-after-write in consecutive accepts.
    drive(0, 1, 1, 1, 27'h200, 4'hf, 32'h11223344);
    adv();
    drive(0, 1, 1, 1, 27'h200, 4'h8, 32'hAA000000);
    adv();
    drive(0, 1, 1, 0, 27'h200, 4'hf, 32'h0);
    @(negedge clk);
    check_eq("t2_c2_ack", 32'(ack_w[0]), 32'h1);
    adv();
    idle(0, 1);
    @(negedge clk);
    check_eq("t2_c3_ack", 32'(ack_w[0]), 32'h1);
    check_eq("t2_c3_hold", dato_w[0], 32'hDEADBEEF);
    adv();
    @(negedge clk);
    check_eq("t2_rd_ack", 32'(ack_w[0]), 32'h1);
    check_eq("t2_rd_dat", dato_w[0], 32'hAA223344);
    adv();
    idle(0, 0);
    adv();

    // Preload four words, then a back-to-back four-word read burst.
    for (int c = 0; c < 12; c++) begin
      if (c < 4)      drive(0, 1, 1, 1, 27'(4 * c), 4'hf, 32'(c + 1));
      else if (c < 8) drive(0, 1, 1, 0, 27'(4 * (c - 4)), 4'hf, 32'h0);
      else            idle(0, 1);
      @(negedge clk);
      check_eq($sformatf("t3_stall_c%0d", c), 32'(stall_w[0]), 32'h0);
      check_eq($sformatf("t3_ack_c%0d", c), 32'(ack_w[0]), (c >= 2 && c <= 9) ? 32'h1 : 32'h0);
      if (c >= 6 && c <= 9) check_eq($sformatf("t3_dat_c%0d", c), dato_w[0], 32'(c - 5));
      if (c == 5) check_eq("t3_hold_c5", dato_w[0], 32'hAA223344);
      adv();
    end
    idle(0, 0);
    adv();

    // STALL_CYCLES 3: four held requests are accepted every fourth cycle.
    for (int c = 0; c < 22; c++) begin
      if (c <= 12)      drive(1, 1, 1, 1, 27'(16 * (c / 4)), 4'hf, 32'(32'h50 + c / 4));
      else if (c == 18) drive(1, 1, 1, 0, 27'h20, 4'hf, 32'h0);
      else              idle(1, 1);
      @(negedge clk);
      check_eq($sformatf("t4_stall_c%0d", c), 32'(stall_w[1]),
               ((c < 16 && (c % 4) != 0) || (c >= 19 && c <= 21)) ? 32'h1 : 32'h0);
      check_eq($sformatf("t4_ack_c%0d", c), 32'(ack_w[1]),
               ((c <= 14 && (c % 4) == 2) || c == 20) ? 32'h1 : 32'h0);
      if (c == 14) check_eq("t4_hold_c14", dato_w[1], 32'h0);
      if (c == 20) check_eq("t4_rd_dat", dato_w[1], 32'h00000052);
      adv();
    end
    idle(1, 0);
    adv();

    // LATENCY 4: cyc drops one cycle after two reads, outstanding acks vanish.
    for (int c = 0; c < 20; c++) begin
      case (c)
        0:       drive(2, 1, 1, 1, 27'h40, 4'hf, 32'h0BADF00D);
        1:       drive(2, 1, 1, 1, 27'h44, 4'hf, 32'h12345678);
        6, 9, 19: idle(2, 0);
        7:       drive(2, 1, 1, 0, 27'h40, 4'hf, 32'h0);
        8:       drive(2, 1, 1, 0, 27'h44, 4'hf, 32'h0);
        13:      drive(2, 1, 1, 0, 27'h44, 4'hf, 32'h0);
        default: idle(2, 1);
      endcase
      @(negedge clk);
      check_eq($sformatf("t5_ack_c%0d", c), 32'(ack_w[2]),
               (c == 4 || c == 5 || c == 17) ? 32'h1 : 32'h0);
      if (c == 11 || c == 12) check_eq($sformatf("t5_dat_c%0d", c), dato_w[2], 32'h0);
      if (c == 17) check_eq("t5_rd_dat", dato_w[2], 32'h12345678);
      if (c == 18) check_eq("t5_hold_c18", dato_w[2], 32'h12345678);
      adv();
    end

    // Reset in the middle of a burst; committed writes survive.
    for (int c = 0; c < 14; c++) begin
      case (c)
        0:       drive(0, 1, 1, 1, 27'h300, 4'hf, 32'hCAFE0001);
        1:       drive(0, 1, 1, 1, 27'h304, 4'hf, 32'hCAFE0002);
        2, 4:    drive(0, 1, 1, 0, 27'h300, 4'hf, 32'h0);
        3, 10:   drive(0, 1, 1, 0, 27'h304, 4'hf, 32'h0);
        5, 6:    begin idle(0, 0); rst = 1'b1; end
        13:      idle(0, 0);
        default: begin idle(0, 1); rst = 1'b0; end
      endcase
      @(negedge clk);
      if (c >= 2 && c <= 4) check_eq($sformatf("t6_ack_c%0d", c), 32'(ack_w[0]), 32'h1);
      if (c == 4) check_eq("t6_pre_dat", dato_w[0], 32'hCAFE0001);
      if (c >= 5 && c <= 9) begin
        check_eq($sformatf("t6_ack_c%0d", c), 32'(ack_w[0]), 32'h0);
        check_eq($sformatf("t6_stall_c%0d", c), 32'(stall_w[0]), 32'h0);
        check_eq($sformatf("t6_dat_c%0d", c), dato_w[0], 32'h0);
      end
      if (c == 12) begin
        check_eq("t6_post_ack", 32'(ack_w[0]), 32'h1);
        check_eq("t6_post_dat", dato_w[0], 32'hCAFE0002);
      end
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
